// File: rtl/sprite_motion_ctrl_pkg.sv
// rtl/sprite_motion_ctrl_pkg.sv - motion state encoding and PS/2 scan codes for the sprite controller
package sprite_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_RUN    = 3'd1,
      ST_RISE   = 3'd2,
      ST_FALL   = 3'd3,
      ST_CROUCH = 3'd4
   } state_t;

   localparam logic [7:0] KEY_UP    = 8'h75;
   localparam logic [7:0] KEY_DOWN  = 8'h72;
   localparam logic [7:0] KEY_LEFT  = 8'h6B;
   localparam logic [7:0] KEY_RIGHT = 8'h74;

endpackage

// File: rtl/sprite_motion_ctrl_tick_divider.sv
// rtl/sprite_motion_ctrl_tick_divider.sv - free-running 0..DIV-1 counter, one-cycle tick at DIV-1
module tick_divider #(
   parameter int DIV = 1000000
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (cnt == CW'(DIV - 1)) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   assign tick = (cnt == CW'(DIV - 1));

endmodule

// File: rtl/sprite_motion_ctrl.sv
// rtl/sprite_motion_ctrl.sv - keyboard-driven sprite run/jump/crouch controller, updated once per motion tick
module sprite_motion_ctrl
   import sprite_pkg::*;
#(
   parameter int POS_W    = 10,
   parameter int VEL_W    = 8,
   parameter int TICK_DIV = 1000000,
   parameter int X_MIN    = 0,
   parameter int X_MAX    = 620,
   parameter int Y_MIN    = 0,
   parameter int GROUND_Y = 300,
   parameter int START_X  = 300,
   parameter int SPEED    = 4,
   parameter int JUMP_V   = 15,
   parameter int GRAVITY  = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             key_valid,
   input  logic [7:0]       key_code,
   input  logic             key_release,
   output logic [POS_W-1:0] pos_x,
   output logic [POS_W-1:0] pos_y,
   output logic [2:0]       state,
   output logic             facing,
   output logic             on_ground,
   output logic             tick
);

   localparam int AW = POS_W + 2;

   localparam logic signed [AW-1:0]    XMIN_S   = X_MIN[AW-1:0];
   localparam logic signed [AW-1:0]    XMAX_S   = X_MAX[AW-1:0];
   localparam logic signed [AW-1:0]    YMIN_S   = Y_MIN[AW-1:0];
   localparam logic signed [AW-1:0]    GROUND_S = GROUND_Y[AW-1:0];
   localparam logic signed [AW-1:0]    SPEED_S  = SPEED[AW-1:0];
   localparam logic signed [VEL_W-1:0] JUMP_S   = JUMP_V[VEL_W-1:0];
   localparam logic signed [VEL_W-1:0] GRAV_S   = GRAVITY[VEL_W-1:0];
   localparam logic signed [VEL_W:0]   VMIN_S   = {2'b11, {(VEL_W-1){1'b0}}};

   state_t                  st, st_n, g_st;
   logic signed [VEL_W-1:0] vel, vel_n, g_vel, v_sat;
   logic signed [VEL_W:0]   v_dec;
   logic signed [AW-1:0]    x_ext, y_ext, v_ext, x_step, y_step;
   logic [POS_W-1:0]        x_n, y_n, x_clamp;
   logic                    face_n, one_h, move_x, valid_st;
   logic                    key_up, key_down, key_left, key_right;

   tick_divider #(.DIV(TICK_DIV)) u_tick (
      .clk  (clk),
      .rst  (rst),
      .tick (tick)
   );

   // Held-key flags follow make/break codes; a make+break between ticks nets to clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         key_up    <= 1'b0;
         key_down  <= 1'b0;
         key_left  <= 1'b0;
         key_right <= 1'b0;
      end else if (key_valid) begin
         case (key_code)
            KEY_UP:    key_up    <= !key_release;
            KEY_DOWN:  key_down  <= !key_release;
            KEY_LEFT:  key_left  <= !key_release;
            KEY_RIGHT: key_right <= !key_release;
            default: ;
         endcase
      end
   end

   always_comb begin
      one_h  = key_left ^ key_right;
      x_ext  = $signed({2'b00, pos_x});
      y_ext  = $signed({2'b00, pos_y});
      v_ext  = {{(AW-VEL_W){vel[VEL_W-1]}}, vel};
      x_step = key_left ? (x_ext - SPEED_S) : (x_ext + SPEED_S);
      y_step = y_ext - v_ext;
      v_dec  = {vel[VEL_W-1], vel} - {GRAV_S[VEL_W-1], GRAV_S};
      v_sat  = (v_dec < VMIN_S) ? VMIN_S[VEL_W-1:0] : v_dec[VEL_W-1:0];

      if (x_step < XMIN_S)      x_clamp = XMIN_S[POS_W-1:0];
      else if (x_step > XMAX_S) x_clamp = XMAX_S[POS_W-1:0];
      else                      x_clamp = x_step[POS_W-1:0];

      g_vel = '0;
      if (key_up) begin
         g_st  = ST_RISE;
         g_vel = JUMP_S;
      end else if (key_down) g_st = ST_CROUCH;
      else if (one_h)        g_st = ST_RUN;
      else                   g_st = ST_IDLE;

      st_n     = st;
      x_n      = pos_x;
      y_n      = pos_y;
      vel_n    = vel;
      move_x   = 1'b0;
      valid_st = 1'b1;

      case (st)
         ST_IDLE, ST_RUN, ST_CROUCH: begin
            st_n   = g_st;
            vel_n  = g_vel;
            move_x = (g_st == ST_RUN);
         end
         ST_RISE: begin
            move_x = 1'b1;
            if (y_step < YMIN_S) begin
               y_n   = YMIN_S[POS_W-1:0];
               vel_n = '0;
               st_n  = ST_FALL;
            end else begin
               y_n   = y_step[POS_W-1:0];
               vel_n = v_dec[VEL_W-1:0];
               if (v_dec[VEL_W] || v_dec == '0) st_n = ST_FALL;
            end
         end
         ST_FALL: begin
            move_x = 1'b1;
            // Landing runs the ground decision in the same tick so a held UP re-jumps at once.
            if (y_step >= GROUND_S) begin
               y_n   = GROUND_S[POS_W-1:0];
               st_n  = g_st;
               vel_n = g_vel;
            end else begin
               y_n   = y_step[POS_W-1:0];
               vel_n = v_sat;
            end
         end
         default: begin
            st_n     = ST_IDLE;
            vel_n    = '0;
            valid_st = 1'b0;
         end
      endcase

      if (move_x && one_h) x_n = x_clamp;
      face_n = (valid_st && one_h) ? key_left : facing;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         st        <= ST_IDLE;
         pos_x     <= START_X[POS_W-1:0];
         pos_y     <= GROUND_Y[POS_W-1:0];
         vel       <= '0;
         facing    <= 1'b0;
         on_ground <= 1'b1;
      end else if (tick) begin
         st        <= st_n;
         pos_x     <= x_n;
         pos_y     <= y_n;
         vel       <= vel_n;
         facing    <= face_n;
         on_ground <= (y_n == GROUND_Y[POS_W-1:0]) && (st_n != ST_RISE) && (st_n != ST_FALL);
      end
   end

   assign state = st;

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// tb/tb_sprite_motion_ctrl.sv - directed bench for sprite_motion_ctrl with TICK_DIV=4
module tb_sprite_motion_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       key_valid;
   logic [7:0] key_code;
   logic       key_release;
   logic [9:0] pos_x, pos_y;
   logic [2:0] state;
   logic       facing, on_ground, tick;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   sprite_motion_ctrl #(.TICK_DIV(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .key_valid   (key_valid),
      .key_code    (key_code),
      .key_release (key_release),
      .pos_x       (pos_x),
      .pos_y       (pos_y),
      .state       (state),
      .facing      (facing),
      .on_ground   (on_ground),
      .tick        (tick)
   );

   task automatic wait_tick(output int cycles);
      cycles = 0;
      do begin
         @(negedge clk);
         cycles++;
      end while (!tick && cycles < 20);
      total++;
      if (!tick) begin
         bad++;
         $display("FAIL tick_timeout: no tick after %0d cycles, tick required", cycles);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic send_key(input logic [7:0] code, input logic rel);
      @(negedge clk);
      key_valid   = 1'b1;
      key_code    = code;
      key_release = rel;
      @(posedge clk);
      #1;
      key_valid = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1; key_valid = 1'b0; key_code = 8'h00; key_release = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      total++; if (pos_x !== 10'd300) begin bad++; $display("FAIL reset_x: got %0d want 300", pos_x); end
      total++; if (pos_y !== 10'd300) begin bad++; $display("FAIL reset_y: got %0d want 300", pos_y); end
      total++; if (state !== 3'd0) begin bad++; $display("FAIL reset_state: got %0d want 0", state); end
      total++; if (facing !== 1'b0) begin bad++; $display("FAIL reset_facing: got %0d want 0", facing); end
      total++; if (on_ground !== 1'b1) begin bad++; $display("FAIL reset_on_ground: got %0d want 1", on_ground); end
      total++; if (tick !== 1'b0) begin bad++; $display("FAIL reset_tick: got %0d want 0", tick); end
   endtask

   task automatic test_idle;
      int c;
      for (int i = 0; i < 20; i++) begin
         wait_tick(c);
         total++; if (c != 4) begin bad++; $display("FAIL idle_period[%0d]: got %0d cycles want 4", i, c); end
         total++;
         if (pos_x !== 10'd300 || pos_y !== 10'd300 || state !== 3'd0 || on_ground !== 1'b1) begin
            bad++;
            $display("FAIL idle_hold[%0d]: got (%0d,%0d) st=%0d og=%0d want (300,300) st=0 og=1",
                     i, pos_x, pos_y, state, on_ground);
         end
      end
   endtask

   task automatic test_run;
      int c;
      send_key(8'h74, 1'b0);
      for (int i = 0; i < 3; i++) begin
         wait_tick(c);
         total++;
         if (pos_x !== 10'(304 + 4 * i) || state !== 3'd1 || facing !== 1'b0) begin
            bad++;
            $display("FAIL run_right[%0d]: got x=%0d st=%0d f=%0d want x=%0d st=1 f=0",
                     i, pos_x, state, facing, 304 + 4 * i);
         end
      end
      send_key(8'h74, 1'b1);
      wait_tick(c);
      total++;
      if (pos_x !== 10'd312 || state !== 3'd0) begin
         bad++; $display("FAIL run_release: got x=%0d st=%0d want x=312 st=0", pos_x, state);
      end
   endtask

   task automatic test_jump;
      int c;
      int ys [16] = '{285, 272, 261, 252, 245, 240, 237, 236, 237, 240, 245, 252, 261, 272, 285, 300};
      int sts[16] = '{2, 2, 2, 2, 2, 2, 2, 3, 3, 3, 3, 3, 3, 3, 3, 0};
      send_key(8'h75, 1'b0);
      wait_tick(c);
      total++;
      if (state !== 3'd2 || pos_y !== 10'd300 || on_ground !== 1'b0) begin
         bad++; $display("FAIL jump_start: got st=%0d y=%0d og=%0d want st=2 y=300 og=0", state, pos_y, on_ground);
      end
      send_key(8'h75, 1'b1);
      for (int i = 0; i < 16; i++) begin
         wait_tick(c);
         total++;
         if (pos_y !== 10'(ys[i]) || state !== 3'(sts[i]) || on_ground !== (i == 15) || pos_x !== 10'd312) begin
            bad++;
            $display("FAIL jump_arc[%0d]: got y=%0d st=%0d og=%0d x=%0d want y=%0d st=%0d og=%0d x=312",
                     i, pos_y, state, on_ground, pos_x, ys[i], sts[i], (i == 15));
         end
      end
   endtask

   task automatic test_both_lr;
      int c;
      send_key(8'h6B, 1'b0);
      send_key(8'h74, 1'b0);
      wait_tick(c);
      total++;
      if (pos_x !== 10'd312 || state !== 3'd0 || facing !== 1'b0) begin
         bad++; $display("FAIL both_lr: got x=%0d st=%0d f=%0d want x=312 st=0 f=0", pos_x, state, facing);
      end
      send_key(8'h6B, 1'b1);
      send_key(8'h74, 1'b1);
   endtask

   task automatic test_crouch_up;
      int c;
      send_key(8'h72, 1'b0);
      send_key(8'h6B, 1'b0);
      wait_tick(c);
      total++;
      if (state !== 3'd4 || pos_x !== 10'd312 || pos_y !== 10'd300 || facing !== 1'b1 || on_ground !== 1'b1) begin
         bad++;
         $display("FAIL crouch_left: got st=%0d x=%0d y=%0d f=%0d og=%0d want st=4 x=312 y=300 f=1 og=1",
                  state, pos_x, pos_y, facing, on_ground);
      end
      send_key(8'h75, 1'b0);
      wait_tick(c);
      total++;
      if (state !== 3'd2 || on_ground !== 1'b0) begin
         bad++; $display("FAIL up_over_down: got st=%0d og=%0d want st=2 og=0", state, on_ground);
      end
      send_key(8'h75, 1'b1);
      send_key(8'h72, 1'b1);
   endtask

   task automatic test_reset_mid_jump;
      int c;
      repeat (3) wait_tick(c);
      total++;
      if (pos_y !== 10'd261 || state !== 3'd2 || pos_x !== 10'd300 || facing !== 1'b1) begin
         bad++;
         $display("FAIL mid_jump: got y=%0d st=%0d x=%0d f=%0d want y=261 st=2 x=300 f=1", pos_y, state, pos_x, facing);
      end
      rst = 1'b1;
      @(negedge clk);
      key_valid = 1'b1; key_code = 8'h6B; key_release = 1'b0;
      @(posedge clk);
      #1;
      key_valid = 1'b0;
      rst = 1'b0;
      total++;
      if (pos_x !== 10'd300 || pos_y !== 10'd300 || state !== 3'd0 || facing !== 1'b0 || on_ground !== 1'b1) begin
         bad++;
         $display("FAIL abort_reset: got (%0d,%0d) st=%0d f=%0d og=%0d want (300,300) st=0 f=0 og=1",
                  pos_x, pos_y, state, facing, on_ground);
      end
      wait_tick(c);
      total++;
      if (state !== 3'd0 || pos_x !== 10'd300 || pos_y !== 10'd300 || facing !== 1'b0) begin
         bad++;
         $display("FAIL flags_cleared: got st=%0d x=%0d y=%0d f=%0d want st=0 x=300 y=300 f=0", state, pos_x, pos_y, facing);
      end
   endtask

   task automatic test_clamp;
      int c;
      send_key(8'h74, 1'b0);
      for (int i = 0; i < 82; i++) begin
         wait_tick(c);
         if (i == 79 || i == 81) begin
            total++;
            if (pos_x !== 10'd620 || state !== 3'd1 || facing !== 1'b0) begin
               bad++; $display("FAIL clamp_max[%0d]: got x=%0d st=%0d f=%0d want x=620 st=1 f=0", i, pos_x, state, facing);
            end
         end
      end
      send_key(8'h74, 1'b1);
      send_key(8'h6B, 1'b0);
      for (int i = 0; i < 157; i++) begin
         wait_tick(c);
         if (i == 154 || i == 156) begin
            total++;
            if (pos_x !== 10'd0 || state !== 3'd1 || facing !== 1'b1) begin
               bad++; $display("FAIL clamp_min[%0d]: got x=%0d st=%0d f=%0d want x=0 st=1 f=1", i, pos_x, state, facing);
            end
         end
      end
      send_key(8'h6B, 1'b1);
      wait_tick(c);
      total++;
      if (state !== 3'd0 || pos_x !== 10'd0 || facing !== 1'b1) begin
         bad++; $display("FAIL clamp_stop: got st=%0d x=%0d f=%0d want st=0 x=0 f=1", state, pos_x, facing);
      end
   endtask

   initial begin
      test_reset();
      test_idle();
      test_run();
      test_jump();
      test_both_lr();
      test_crouch_up();
      test_reset_mid_jump();
      test_clamp();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
